uart_cmd_port: RTL

//  Device-side endpoint of the host UART command protocol inside DSO_dig.

---
 rtl/dso_cmd_pkg.sv | 39 +++
 rtl/uart_resp_tx.sv | 64 ++++++
 rtl/uart_cmd_port.sv | 106 ++++++++++
 3 files changed

// File: rtl/dso_cmd_pkg.sv
// Shared definitions for the DSO_dig host command protocol: opcodes, acknowledge
// codes, the assembled command layout and the RX/TX endpoint state encodings.
package dso_cmd_pkg;

    localparam logic [7:0] DUMP_CH    = 8'h01;
    localparam logic [7:0] CFG_GAIN   = 8'h02;
    localparam logic [7:0] TRIG_LVL   = 8'h03;
    localparam logic [7:0] TRIG_POS   = 8'h04;
    localparam logic [7:0] SET_DEC    = 8'h05;
    localparam logic [7:0] TRIG_CFG   = 8'h06;
    localparam logic [7:0] CAL_OFFSET = 8'h07;
    localparam logic [7:0] EEP_WR     = 8'h08;
    localparam logic [7:0] EEP_RD     = 8'h09;

    localparam logic [7:0] POS_ACK = 8'hA5;
    localparam logic [7:0] NEG_ACK = 8'hEE;

    localparam int TMO_W = 16;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] arg1;
        logic [7:0] arg2;
    } cmd_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_CAPTURE,
        RX_SKIP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_WAIT_LO,
        TX_WAIT_HI
    } tx_state_t;

endpackage

// File: rtl/uart_resp_tx.sv
// Response serialiser: latches one response byte, kicks the transceiver and
// reports completion once tx_done has been seen low and then high again.
module uart_resp_tx
    import dso_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] resp_data,
    input  logic       send_resp,
    input  logic       uart_tx_done,
    output logic       uart_trmt,
    output logic [7:0] uart_tx_data,
    output logic       resp_busy,
    output logic       resp_sent
);

    tx_state_t state, state_next;
    logic      load, trmt_next, sent_next;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        trmt_next  = 1'b0;
        sent_next  = 1'b0;
        case (state)
            TX_IDLE: begin
                if (send_resp) begin
                    load       = 1'b1;
                    state_next = TX_LOAD;
                end
            end
            TX_LOAD: begin
                trmt_next  = 1'b1;
                state_next = TX_WAIT_LO;
            end
            // A done level left over from the previous byte must not end this one.
            TX_WAIT_LO: if (!uart_tx_done) state_next = TX_WAIT_HI;
            TX_WAIT_HI: begin
                if (uart_tx_done) begin
                    sent_next  = 1'b1;
                    state_next = TX_IDLE;
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= TX_IDLE;
            uart_trmt    <= 1'b0;
            uart_tx_data <= '0;
            resp_busy    <= 1'b0;
            resp_sent    <= 1'b0;
        end else begin
            state     <= state_next;
            uart_trmt <= trmt_next;
            resp_sent <= sent_next;
            resp_busy <= load | (resp_busy & ~sent_next);
            if (load) uart_tx_data <= resp_data;
        end
    end

endmodule

// File: rtl/uart_cmd_port.sv
// Host UART command endpoint: assembles 3-byte commands into one 24-bit word with
// an inter-byte timeout, and returns 1-byte responses through uart_resp_tx.
module uart_cmd_port
    import dso_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rdy,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_clr_rdy,
    output logic        uart_trmt,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_done,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic        resp_busy,
    output logic        resp_sent,
    output logic        timeout_err
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    rx_state_t        rx_state, rx_next;
    cmd_t             cmd_q;
    logic [1:0]       byte_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             capture, tmo_run, tmo_hit;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rx_next = rx_state;
        capture = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (uart_rdy && !cmd_rdy) begin
                    capture = 1'b1;
                    rx_next = (byte_cnt == 2'd2) ? RX_CAPTURE : RX_SKIP;
                end
            end
            RX_CAPTURE: rx_next = RX_IDLE;
            RX_SKIP:    rx_next = RX_IDLE;
            default:    rx_next = RX_IDLE;
        endcase
    end

    assign tmo_run = (byte_cnt == 2'd1) || (byte_cnt == 2'd2);
    assign tmo_hit = tmo_run && (tmo_cnt == TMO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q        <= '0;
            byte_cnt     <= '0;
            tmo_cnt      <= '0;
            cmd_rdy      <= 1'b0;
            uart_clr_rdy <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            uart_clr_rdy <= capture;
            timeout_err  <= 1'b0;
            if (capture) begin
                cmd_q    <= '{opcode: cmd_q.arg1, arg1: cmd_q.arg2, arg2: uart_rx_data};
                byte_cnt <= byte_cnt + 2'd1;
                tmo_cnt  <= '0;
            end else if (tmo_hit) begin
                byte_cnt    <= '0;
                tmo_cnt     <= '0;
                timeout_err <= 1'b1;
            end else if (tmo_run) begin
                tmo_cnt <= tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
            end
            // The cycle after the third capture publishes the word and rearms the count.
            if (rx_state == RX_CAPTURE) begin
                cmd_rdy  <= 1'b1;
                byte_cnt <= '0;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    assign cmd = cmd_q;

    uart_resp_tx u_resp_tx (
        .clk          (clk),
        .rst_n        (rst_n),
        .resp_data    (resp_data),
        .send_resp    (send_resp),
        .uart_tx_done (uart_tx_done),
        .uart_trmt    (uart_trmt),
        .uart_tx_data (uart_tx_data),
        .resp_busy    (resp_busy),
        .resp_sent    (resp_sent)
    );

endmodule
